// File: rtl/vend_change_dispenser_if.sv
// Handshake bundle between the vending core/coin hopper side (master) and the
// change dispenser (slave).
interface vend_change_dispenser_if #(
    parameter int unsigned CW = 6
);
    logic          start;
    logic [CW-1:0] credit_n;
    logic          vend;
    logic          hopper_req;
    logic [1:0]    coin_sel;
    logic          hopper_ack;
    logic [CW-1:0] remaining;
    logic          busy;
    logic          done;
    logic          err;
    logic          candy_ok;

    modport master (
        output start, credit_n, vend, hopper_ack,
        input  hopper_req, coin_sel, remaining, busy, done, err, candy_ok
    );

    modport slave (
        input  start, credit_n, vend, hopper_ack,
        output hopper_req, coin_sel, remaining, busy, done, err, candy_ok
    );
endinterface

// File: rtl/vend_change_dispenser.sv
// Change-return controller: greedy quarter/dime/nickel payout over one hopper
// handshake with a response timeout. Optional audit counters: CHANGE_AUDIT_EN.
module vend_change_dispenser #(
    parameter int unsigned PRICE_N = 5,
    parameter int unsigned TO_CYC  = 15,
    parameter int unsigned CW      = 6
) (
    input  logic                    Clk,
    input  logic                    Rst,
    vend_change_dispenser_if.slave  bus
`ifdef CHANGE_AUDIT_EN
    ,
    output logic [7:0]              cnt_q,
    output logic [7:0]              cnt_d,
    output logic [7:0]              cnt_n
`endif
);

    localparam int unsigned   TW      = $clog2(TO_CYC + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TO_CYC - 1);
    localparam logic [CW-1:0] PRICE   = CW'(PRICE_N);
    localparam logic [CW-1:0] VAL_Q   = CW'(5);
    localparam logic [CW-1:0] VAL_D   = CW'(2);
    localparam logic [CW-1:0] VAL_N   = CW'(1);
    localparam logic [1:0]    SEL_N   = 2'b00;
    localparam logic [1:0]    SEL_D   = 2'b01;
    localparam logic [1:0]    SEL_Q   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_ISSUE,
        S_WAIT,
        S_GAP,
        S_FIN,
        S_FAULT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] credit_q, credit_d;
    logic          vend_q, vend_d;
    logic [CW-1:0] rem_q, rem_d;
    logic          paid_q, paid_d;
    logic [1:0]    sel_q, sel_d;
    logic [TW-1:0] to_q, to_d;
    logic [CW-1:0] coin_val;
    logic          coin_ack;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= S_IDLE;
            credit_q <= '0;
            vend_q   <= 1'b0;
            rem_q    <= '0;
            paid_q   <= 1'b0;
            sel_q    <= '0;
            to_q     <= '0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            vend_q   <= vend_d;
            rem_q    <= rem_d;
            paid_q   <= paid_d;
            sel_q    <= sel_d;
            to_q     <= to_d;
        end
    end

    always_comb begin
        coin_val = VAL_N;
        case (sel_q)
            SEL_Q:   coin_val = VAL_Q;
            SEL_D:   coin_val = VAL_D;
            default: coin_val = VAL_N;
        endcase
    end

    assign coin_ack = (state_q == S_WAIT) && bus.hopper_ack;

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        vend_d   = vend_q;
        rem_d    = rem_q;
        paid_d   = paid_q;
        sel_d    = sel_q;
        to_d     = to_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    credit_d = bus.credit_n;
                    vend_d   = bus.vend;
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                if (vend_q && (credit_q >= PRICE)) begin
                    rem_d  = credit_q - PRICE;
                    paid_d = 1'b1;
                end else begin
                    rem_d  = credit_q;
                    paid_d = 1'b0;
                end
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (rem_q == '0) begin
                    state_d = S_FIN;
                end else begin
                    if (rem_q >= VAL_Q) begin
                        sel_d = SEL_Q;
                    end else if (rem_q >= VAL_D) begin
                        sel_d = SEL_D;
                    end else begin
                        sel_d = SEL_N;
                    end
                    to_d    = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // An ack in the final allowed cycle still completes the coin.
                if (bus.hopper_ack) begin
                    rem_d   = rem_q - coin_val;
                    state_d = S_GAP;
                end else if (to_q == TO_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            S_GAP:   state_d = S_ISSUE;
            S_FIN:   state_d = S_IDLE;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.hopper_req = (state_q == S_WAIT);
    assign bus.coin_sel   = sel_q;
    assign bus.remaining  = rem_q;
    assign bus.busy       = (state_q == S_CALC) || (state_q == S_ISSUE) ||
                            (state_q == S_WAIT) || (state_q == S_GAP) ||
                            (state_q == S_FIN);
    assign bus.done       = (state_q == S_FIN);
    assign bus.candy_ok   = (state_q == S_FIN) && paid_q;
    assign bus.err        = (state_q == S_FAULT);

`ifdef CHANGE_AUDIT_EN
    logic [7:0] audq_q, audd_q, audn_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            audq_q <= '0;
            audd_q <= '0;
            audn_q <= '0;
        end else if (coin_ack) begin
            case (sel_q)
                SEL_Q:   audq_q <= audq_q + 8'd1;
                SEL_D:   audd_q <= audd_q + 8'd1;
                default: audn_q <= audn_q + 8'd1;
            endcase
        end
    end

    assign cnt_q = audq_q;
    assign cnt_d = audd_q;
    assign cnt_n = audn_q;
`else
    logic unused_ack;
    assign unused_ack = coin_ack;
`endif

endmodule

// File: tb/tb_vend_change_dispenser.sv
// Directed bench for vend_change_dispenser: exact pay, overpay, refund,
// underpay, ack-on-last-cycle, reset mid-request, timeout fault.
module tb_vend_change_dispenser;

    localparam int unsigned CW = 6;

    logic Clk = 1'b0;
    logic Rst;
    always #5 Clk = ~Clk;

    vend_change_dispenser_if #(.CW(CW)) bus ();

`ifdef CHANGE_AUDIT_EN
    logic [7:0] aq, ad, an;
`endif

    vend_change_dispenser #(
        .PRICE_N(5),
        .TO_CYC (15),
        .CW     (CW)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .bus(bus)
`ifdef CHANGE_AUDIT_EN
        ,
        .cnt_q(aq),
        .cnt_d(ad),
        .cnt_n(an)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_req"},   32'(bus.hopper_req), 32'd0);
        check({tag, "_busy"},  32'(bus.busy),       32'd0);
        check({tag, "_done"},  32'(bus.done),       32'd0);
        check({tag, "_candy"}, 32'(bus.candy_ok),   32'd0);
        check({tag, "_err"},   32'(bus.err),        32'd0);
        check({tag, "_rem"},   32'(bus.remaining),  32'd0);
    endtask

    // Leaves the bench in the ISSUE cycle after CALC.
    task automatic start_txn(input string tag, input int credit, input bit v, input int exp_rem);
        bus.start    = 1'b1;
        bus.credit_n = CW'(credit);
        bus.vend     = v;
        tick();
        bus.start = 1'b0;
        check({tag, "_calc_busy"}, 32'(bus.busy), 32'd1);
        check({tag, "_calc_req"},  32'(bus.hopper_req), 32'd0);
        tick();
        check({tag, "_rem0"}, 32'(bus.remaining), 32'(exp_rem));
    endtask

    // Entered and left in an ISSUE cycle.
    task automatic serve_coin(input string tag, input int sel, input int rem_after,
                              input int delay, input bit poke_start);
        check({tag, "_issue_req"}, 32'(bus.hopper_req), 32'd0);
        if (poke_start) begin
            bus.start    = 1'b1;
            bus.credit_n = '0;
            bus.vend     = 1'b0;
        end
        tick();
        bus.start = 1'b0;
        check({tag, "_req"}, 32'(bus.hopper_req), 32'd1);
        check({tag, "_sel"}, 32'(bus.coin_sel),   32'(sel));
        for (int i = 0; i < delay; i++) begin
            tick();
            check({tag, "_req_hold"}, 32'(bus.hopper_req), 32'd1);
            check({tag, "_sel_hold"}, 32'(bus.coin_sel),   32'(sel));
        end
        bus.hopper_ack = 1'b1;
        tick();
        bus.hopper_ack = 1'b0;
        check({tag, "_gap_req"}, 32'(bus.hopper_req), 32'd0);
        check({tag, "_rem"},     32'(bus.remaining),  32'(rem_after));
        check({tag, "_gap_err"}, 32'(bus.err),        32'd0);
        tick();
    endtask

    task automatic finish_txn(input string tag, input bit candy);
        check({tag, "_last_req"}, 32'(bus.hopper_req), 32'd0);
        tick();
        check({tag, "_done"},  32'(bus.done),      32'd1);
        check({tag, "_candy"}, 32'(bus.candy_ok),  32'(candy));
        check({tag, "_fbusy"}, 32'(bus.busy),      32'd1);
        check({tag, "_frem"},  32'(bus.remaining), 32'd0);
        tick();
        check({tag, "_done_off"},  32'(bus.done),     32'd0);
        check({tag, "_candy_off"}, 32'(bus.candy_ok), 32'd0);
        check({tag, "_idle_busy"}, 32'(bus.busy),     32'd0);
    endtask

    initial begin
        int n;
        Rst            = 1'b1;
        bus.start      = 1'b0;
        bus.credit_n   = '0;
        bus.vend       = 1'b0;
        bus.hopper_ack = 1'b0;
        tick();
        tick();
        Rst = 1'b0;
        check_quiet("reset");
        check("reset_sel", 32'(bus.coin_sel), 32'd0);

        // exact payment: no coins, done three cycles after start
        start_txn("exact", 5, 1'b1, 0);
        check("exact_issue_done", 32'(bus.done), 32'd0);
        finish_txn("exact", 1'b1);

        // 45c vend: 4 nickels change -> dime, dime
        start_txn("over", 9, 1'b1, 4);
        serve_coin("over_c1", 1, 2, 1, 1'b0);
        serve_coin("over_c2", 1, 0, 1, 1'b0);
        finish_txn("over", 1'b1);

        // refund 8: quarter, dime, nickel
        start_txn("refund", 8, 1'b0, 8);
        serve_coin("refund_c1", 2, 3, 0, 1'b0);
        serve_coin("refund_c2", 1, 1, 2, 1'b0);
        serve_coin("refund_c3", 0, 0, 0, 1'b0);
        finish_txn("refund", 1'b0);

        // underpay 3: dime (acked on the last allowed cycle, stray start), nickel
        start_txn("under", 3, 1'b1, 3);
        serve_coin("under_c1", 1, 1, 14, 1'b1);
        serve_coin("under_c2", 0, 0, 0, 1'b0);
        finish_txn("under", 1'b0);

`ifdef CHANGE_AUDIT_EN
        check("audit_q", 32'(aq), 32'd1);
        check("audit_d", 32'(ad), 32'd4);
        check("audit_n", 32'(an), 32'd2);
`endif

        // ack while idle is ignored
        bus.hopper_ack = 1'b1;
        tick();
        bus.hopper_ack = 1'b0;
        check_quiet("idle_ack");

        // max credit, reset while the first quarter is in flight
        start_txn("max", 63, 1'b1, 58);
        tick();
        check("max_req", 32'(bus.hopper_req), 32'd1);
        check("max_sel", 32'(bus.coin_sel),   32'd2);
        bus.hopper_ack = 1'b1;
        Rst            = 1'b1;
        tick();
        bus.hopper_ack = 1'b0;
        Rst            = 1'b0;
        check_quiet("midrst");
        check("midrst_sel", 32'(bus.coin_sel), 32'd0);
`ifdef CHANGE_AUDIT_EN
        check("midrst_audit_q", 32'(aq), 32'd0);
`endif

        // hopper never acks: fault after 15 request cycles
        start_txn("to", 6, 1'b1, 1);
        tick();
        n = 0;
        while (bus.hopper_req === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        check("to_req_cycles", 32'(n), 32'd15);
        check("to_err",  32'(bus.err),        32'd1);
        check("to_req",  32'(bus.hopper_req), 32'd0);
        check("to_busy", 32'(bus.busy),       32'd0);
        check("to_rem",  32'(bus.remaining),  32'd1);
        bus.start    = 1'b1;
        bus.credit_n = CW'(5);
        bus.vend     = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("fault_err",  32'(bus.err),       32'd1);
            check("fault_busy", 32'(bus.busy),      32'd0);
            check("fault_done", 32'(bus.done),      32'd0);
            check("fault_rem",  32'(bus.remaining), 32'd1);
        end
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        check_quiet("fault_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vend_change_dispenser.md
Name: vend_change_dispenser

Overview:
Change-return controller that follows the vending FSM. On a vend or refund request it computes the change owed in nickel units and sequences a single shared coin hopper, one coin per request/ack handshake, using a greedy order: quarter, then dime, then nickel. It reports busy/done/error status back to the vending core. It has one hopper-response timeout and a sticky fault.

Parameters:
PRICE_N, 5, item price in nickels (5 = 25 cents)
TO_CYC, 15, max cycles hopper_req may stay high without hopper_ack before fault
CW, 6, width of credit/remaining counters in nickels

Ports:
Clk  in  1  clock; all logic on rising edge
Rst  in  1  reset, synchronous, active-high
start  in  1  one-cycle request to begin a transaction; sampled only in IDLE
credit_n  in  CW  credit held by vending core, in nickels; sampled with start
vend  in  1  sampled with start: 1 = sell item, 0 = full refund
hopper_req  out  1  coin eject request to hopper
coin_sel  out  2  coin to eject: 2'b00 nickel, 2'b01 dime, 2'b10 quarter; 2'b11 never driven
hopper_ack  in  1  hopper has ejected the selected coin
remaining  out  CW  change still owed, in nickels
busy  out  1  transaction in progress
done  out  1  one-cycle pulse when a transaction completes without error
err  out  1  sticky fault flag, cleared only by Rst
candy_ok  out  1  one-cycle pulse, same cycle as done, when vend=1 and the item was paid

Behaviour:
- Reset values: all outputs 0; state IDLE; remaining=0.
- States: IDLE, CALC, ISSUE, WAIT, GAP, FIN, FAULT.
- IDLE:
  - start=1 latches credit_n and vend, then goes to CALC next cycle.
  - start is ignored in every other state; no queueing.
- CALC (1 cycle), busy=1:
  - vend=1 and credit_n >= PRICE_N: remaining <= credit_n - PRICE_N, paid flag set.
  - vend=1 and credit_n < PRICE_N: remaining <= credit_n (full refund), paid flag clear.
  - vend=0: remaining <= credit_n, paid flag clear.
  - Next state is ISSUE.
- ISSUE:
  - remaining=0: go to FIN.
  - Otherwise select coin_sel as quarter if remaining>=5, else dime if >=2, else nickel.
  - Assert hopper_req, load the timeout counter to 0, go to WAIT.
- WAIT:
  - hopper_req held 1; coin_sel held stable.
  - hopper_ack=1: remaining decrements by coin value (5/2/1) in the same edge; go to GAP.
  - Else the counter increments; when the counter reaches TO_CYC with no ack, drop req, set err, go to FAULT.
  - If ack arrives in the same cycle the counter would hit TO_CYC, ack wins.
- GAP: hopper_req=0 for exactly one cycle, then ISSUE. Back-to-back requests are always separated by at least one low cycle.
- FIN:
  - Pulse done=1 for one cycle, plus candy_ok if the paid flag is set.
  - Deassert busy, return to IDLE.
  - busy is 1 from the cycle after start through the FIN cycle inclusive.
- FAULT: terminal. hopper_req=0, busy=0, err=1, remaining frozen. Only Rst exits.
- hopper_ack outside WAIT is ignored.
- Rst mid-transaction: next edge returns to IDLE with all outputs 0. A coin in flight is not counted.
- Arithmetic:
  - Unsigned, CW bits; remaining never underflows because the greedy selection guarantees coin value <= remaining.
  - credit_n = 2^CW-1 is legal.
- Minimum transaction latency, start to done:
  - 3 cycles with zero change.
  - Each coin adds 2 + (ack delay) cycles.

Optional Feature:
CHANGE_AUDIT_EN
- Defined: adds outputs cnt_q, cnt_d, cnt_n (each 8 bits, wrap at 255). Each increments on every acknowledged coin of its type. They reset only on Rst and persist across transactions.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Exact payment: start with credit_n=5, vend=1 -> no hopper_req; done and candy_ok pulse 3 cycles after start; remaining=0.
- Overpay: credit_n=9 (45c), vend=1, ack 1 cycle after each req -> coins dime, dime in order; done+candy_ok; remaining 4->2->0.
- Refund: credit_n=8, vend=0 -> quarter, dime, nickel; done pulses, candy_ok stays 0.
- Underpay: credit_n=3, vend=1 -> dime, nickel refunded; candy_ok=0.
- Timeout: credit_n=6, vend=1, hopper_ack held low -> hopper_req high 15 cycles then drops; err=1 sticky; remaining=1; start ignored until Rst.
- Reset mid-WAIT plus start ignored while busy: Rst during a coin request -> next cycle all outputs 0, state IDLE. A start pulse during busy does not alter the transaction.
